// File: rtl/fsm3_evcnt_pkg.sv
// Shared constants and helpers for the windowed detect-event counter.
package fsm3_evcnt_pkg;

    localparam int unsigned WINDOW_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 8;

    // a + b clamped to the largest value representable in w bits (w <= 32)
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [31:0] maxv;
        maxv = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        sum  = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, maxv}) ? maxv : sum[31:0];
    endfunction

endpackage

// File: rtl/evcnt_fifo2.sv
// Two-entry shift FIFO; entry e0 is always the head.
module evcnt_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [1:0]   count;
    logic         pop_ok_c;
    logic         push_ok_c;

    always_comb begin
        full      = (count == 2'd2);
        empty     = (count == 2'd0);
        pop_ok_c  = pop & ~empty;
        push_ok_c = push & (~full | pop_ok_c);
        dout      = e0;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (clr) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else begin
            case ({push_ok_c, pop_ok_c})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // simultaneous pop keeps occupancy; new entry lands behind the survivor
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fsm3_event_counter.sv
// Counts rising edges of det per WINDOW-cycle window and queues each window's count.
module fsm3_event_counter
    import fsm3_evcnt_pkg::*;
#(
    parameter int unsigned WINDOW = WINDOW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             det,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             ovf
);

    localparam int unsigned       WCNT_W    = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);

    logic              det_q;
    logic [WCNT_W-1:0] wcnt;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  head;
    logic [CNT_W-1:0]  result_c;
    logic              det_edge_c;
    logic              close_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic              full;
    logic              empty;

    always_comb begin
        det_edge_c = det & ~det_q;
        close_c    = (wcnt == WCNT_LAST);
        result_c   = CNT_W'(sat_add(32'(acc), 32'(det_edge_c), CNT_W));
        pop_c      = ~empty & cnt_ready;
        // clear wins over a coincident window close
        push_c     = close_c & ~clr & (~full | pop_c);
        drop_c     = close_c & ~clr & full & ~pop_c;
        cnt_valid  = ~empty;
        cnt_data   = empty ? '0 : head;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) det_q <= 1'b0;
        else         det_q <= det;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wcnt <= '0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            wcnt <= '0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else begin
            wcnt <= close_c ? '0 : wcnt + WCNT_W'(1);
            acc  <= close_c ? '0 : result_c;
            if (drop_c) ovf <= 1'b1;
        end
    end

    evcnt_fifo2 #(.W(CNT_W)) u_fifo (
        .clk    (clk),
        .areset (areset),
        .clr    (clr),
        .push   (push_c),
        .din    (result_c),
        .pop    (pop_c),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_fsm3_event_counter.sv
// Directed bench for fsm3_event_counter (default build plus a CNT_W=3 build).
module tb_fsm3_event_counter;

    logic       clk;
    logic       areset;
    logic       det;
    logic       clr;
    logic       cnt_ready;
    logic [7:0] cnt_data;
    logic       cnt_valid;
    logic       ovf;
    logic [2:0] cnt_data3;
    logic       cnt_valid3;
    logic       ovf3;

    int checks = 0;
    int errors = 0;

    fsm3_event_counter dut (
        .clk       (clk),
        .areset    (areset),
        .det       (det),
        .clr       (clr),
        .cnt_data  (cnt_data),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .ovf       (ovf)
    );

    fsm3_event_counter #(.WINDOW(16), .CNT_W(3)) dut3 (
        .clk       (clk),
        .areset    (areset),
        .det       (det),
        .clr       (clr),
        .cnt_data  (cnt_data3),
        .cnt_valid (cnt_valid3),
        .cnt_ready (cnt_ready),
        .ovf       (ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        areset    = 1'b0;
        det       = 1'b0;
        clr       = 1'b0;
        cnt_ready = 1'b1;
        cyc();
        cyc();
        areset = 1'b1;
    endtask

    task automatic test_reset();
        areset    = 1'b0;
        det       = 1'b1;
        clr       = 1'b0;
        cnt_ready = 1'b1;
        cyc();
        cyc();
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%0d ovf=%b, expected 0/0/0", cnt_valid, cnt_data, ovf);
        end
        checks++;
        if (cnt_valid3 !== 1'b0 || cnt_data3 !== 3'd0 || ovf3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w3: valid=%b data=%0d ovf=%b, expected 0/0/0", cnt_valid3, cnt_data3, ovf3);
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            det = (i % 2 == 0);
            cyc();
            if (i == 14) begin
                checks++;
                if (cnt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL toggle_early: valid=%b before close, expected 0", cnt_valid);
                end
            end
        end
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd8 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL toggle_out: valid=%b data=%0d ovf=%b, expected 1/8/0", cnt_valid, cnt_data, ovf);
        end
        det = 1'b0;
        cyc();
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0) begin
            errors++;
            $display("FAIL toggle_pop: valid=%b data=%0d, expected 0/0", cnt_valid, cnt_data);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        det = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cyc();
            if (i == 15) begin
                checks++;
                if (cnt_valid !== 1'b1 || cnt_data !== 8'd1) begin
                    errors++;
                    $display("FAIL hold_first: valid=%b data=%0d, expected 1/1", cnt_valid, cnt_data);
                end
            end
            if (i == 16) begin
                checks++;
                if (cnt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_gap: valid=%b, expected 0", cnt_valid);
                end
            end
        end
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd0) begin
            errors++;
            $display("FAIL hold_second: valid=%b data=%0d, expected 1/0", cnt_valid, cnt_data);
        end
        det = 1'b0;
    endtask

    task automatic test_overflow();
        apply_reset();
        cnt_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 16; j++) begin
                det = (j == 0 || j == 2);
                cyc();
            end
            checks++;
            if (cnt_valid !== 1'b1 || cnt_data !== 8'd2 || ovf !== (w == 2)) begin
                errors++;
                $display("FAIL ovf_window%0d: valid=%b data=%0d ovf=%b, expected 1/2/%0d",
                         w, cnt_valid, cnt_data, ovf, (w == 2));
            end
        end
        det       = 1'b0;
        cnt_ready = 1'b1;
        cyc();
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd2) begin
            errors++;
            $display("FAIL ovf_drain2: valid=%b data=%0d, expected 1/2", cnt_valid, cnt_data);
        end
        cyc();
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained: valid=%b data=%0d ovf=%b, expected 0/0/1", cnt_valid, cnt_data, ovf);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b, expected 0", ovf);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cnt_ready = 1'b0;
        for (int j = 0; j < 16; j++) begin
            det = (j == 0);
            cyc();
        end
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd1) begin
            errors++;
            $display("FAIL rmid_pre: valid=%b data=%0d, expected 1/1", cnt_valid, cnt_data);
        end
        for (int j = 0; j < 9; j++) begin
            det = (j % 2 == 0) && (j < 8);
            cyc();
        end
        areset = 1'b0;
        det    = 1'b1;
        #1;
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: valid=%b data=%0d ovf=%b, expected 0/0/0", cnt_valid, cnt_data, ovf);
        end
        cyc();
        areset    = 1'b1;
        cnt_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            det = (j < 3 || j == 5);
            cyc();
            if (j == 14) begin
                checks++;
                if (cnt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rmid_early: valid=%b, expected 0", cnt_valid);
                end
            end
        end
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd2) begin
            errors++;
            $display("FAIL rmid_out: valid=%b data=%0d, expected 1/2", cnt_valid, cnt_data);
        end
        det = 1'b0;
    endtask

    task automatic test_clr_close();
        apply_reset();
        cnt_ready = 1'b0;
        for (int j = 0; j < 16; j++) begin
            det = (j == 0);
            cyc();
        end
        for (int j = 0; j < 16; j++) begin
            det = (j <= 8) && (j % 2 == 0);
            clr = (j == 15);
            cyc();
        end
        clr = 1'b0;
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_close: valid=%b data=%0d ovf=%b, expected 0/0/0", cnt_valid, cnt_data, ovf);
        end
        cnt_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            det = (j == 1 || j == 3 || j == 5);
            cyc();
            if (j == 14) begin
                checks++;
                if (cnt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_early: valid=%b, expected 0", cnt_valid);
                end
            end
        end
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd3) begin
            errors++;
            $display("FAIL clr_next: valid=%b data=%0d, expected 1/3", cnt_valid, cnt_data);
        end
        det = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            det = (i % 2 == 0);
            cyc();
        end
        checks++;
        if (cnt_valid3 !== 1'b1 || cnt_data3 !== 3'd7 || ovf3 !== 1'b0) begin
            errors++;
            $display("FAIL saturate: valid=%b data=%0d ovf=%b, expected 1/7/0", cnt_valid3, cnt_data3, ovf3);
        end
        det = 1'b0;
    endtask

    initial begin
        areset    = 1'b0;
        det       = 1'b0;
        clr       = 1'b0;
        cnt_ready = 1'b1;
        test_reset();
        test_toggle();
        test_hold();
        test_overflow();
        test_reset_mid();
        test_clr_close();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm3_event_counter.md
FSM3_EVENT_COUNTER -- requirements
Module: fsm3_event_counter

Interface
REQ-001 SHALL have parameter WINDOW, default 16, giving the window length in clk cycles (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of each per-window event count.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-low reset; asserts immediately and deasserts synchronously to clk.
REQ-005 SHALL have port det  input  1  level from the upstream pattern-detect FSM (high while that FSM is in its detect state).
REQ-006 SHALL have port clr  input  1  synchronous soft clear.
REQ-007 SHALL have port cnt_data  output  CNT_W  event count at the head of the output buffer.
REQ-008 SHALL have port cnt_valid  output  1  cnt_data is valid.
REQ-009 SHALL have port cnt_ready  input  1  the consumer accepts cnt_data.
REQ-010 SHALL have port ovf  output  1  sticky flag: a window result was dropped.

Function
REQ-011 SHALL register det into det_q each cycle, and define edge = det AND NOT det_q.
REQ-012 SHALL run window counter wcnt from 0 to WINDOW-1, incrementing every cycle and wrapping to 0 after WINDOW-1.
REQ-013 SHALL add edge to accumulator acc every cycle; acc saturates at 2^CNT_W-1 and never wraps.
REQ-014 SHALL treat the cycle with wcnt==WINDOW-1 as window close: result = sat(acc+edge), push the result into the buffer, and load acc with 0 for the next cycle.
REQ-015 SHALL count an edge in the window close cycle in the closing window; an edge in the following cycle counts in the new window.
REQ-016 SHALL implement the output buffer as a 2-entry FIFO: cnt_valid = not empty; cnt_data = head entry; pop when cnt_valid AND cnt_ready.
REQ-017 SHALL make a pushed result visible on cnt_valid/cnt_data in the cycle after window close (latency 1).
REQ-018 SHALL hold cnt_data stable while cnt_valid=1 and cnt_ready=0.
REQ-019 SHALL accept a push in a window close cycle when the buffer is full only if a pop occurs in the same cycle; order is preserved.
REQ-020 SHALL drop the result when the buffer is full with no pop in a window close cycle, and set ovf=1; ovf then stays 1 until clr or reset.
REQ-021 SHALL, on clr=1, set wcnt=0, acc=0, empty the buffer and set ovf=0 in the next cycle; det_q keeps tracking det.
REQ-022 SHALL give clr priority over a simultaneous window close: no push and no ovf set.
REQ-023 SHALL drive cnt_data to 0 when the buffer is empty.

Reset
REQ-024 SHALL, while areset=0, force det_q=0, wcnt=0, acc=0, buffer empty, cnt_valid=0, cnt_data=0 and ovf=0.
REQ-025 SHALL abandon any partially counted window when reset is asserted mid-window; counting restarts at wcnt=0 on the first clk edge after release.
REQ-026 SHALL count a det that is already high at reset release as one edge in the first cycle, because det_q resets to 0.

Structure
REQ-027 SHALL place the WINDOW and CNT_W default constants and a saturating-add helper in shared package fsm3_evcnt_pkg.
REQ-028 SHALL implement the output buffer as sub-module evcnt_fifo2 (2-deep, parameter width, push/pop/full/empty, async active-low reset).

Verification (WINDOW=16, CNT_W=8 unless stated; cnt_ready=1 unless stated)
REQ-029 SHALL cover: det toggling 1,0 every cycle for 16 cycles from reset release -> one output with cnt_data=8 one cycle after close.
REQ-030 SHALL cover: det held 1 from reset release for 32 cycles -> outputs 1 then 0.
REQ-031 SHALL cover: cnt_ready=0 for 3 windows of 2 edges each -> ovf=1 after the third close; on raising cnt_ready, exactly two outputs (2, 2) appear, then cnt_valid=0.
REQ-032 SHALL cover: CNT_W=3 with det toggling for one window -> cnt_data=7 (saturated), ovf=0.
REQ-033 SHALL cover: areset pulsed low at wcnt=9 after 4 edges -> all outputs 0 at once; the next window closes 16 cycles after release and counts only post-reset edges.
REQ-034 SHALL cover: clr asserted in a window close cycle with 5 edges counted, buffer holding one entry -> buffer empty, no new output, ovf=0.
